serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial multi-bit subtractor: computes diff = a − b − borrow_in over WIDTH clock cycles, one bit per cycle LSB-first, using the single-bit full-subtractor equations with a registered borrow. It sits directly downstream of the operand source and wraps the one-bit full-subtractor cell in a sequential datapath. Operands and results pass through valid/ready handshakes, so the block drops into a streaming pipeline.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- borrow_in  input  1  initial borrow into bit 0.
- out_valid  output  1  diff/borrow_out hold a completed result.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a − b − borrow_in modulo 2^WIDTH.
- borrow_out  output  1  borrow out of bit WIDTH−1; 1 iff a < b + borrow_in.
- busy  output  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0. Internal operand shift registers, borrow register and bit counter are all cleared.
- IDLE:
  - On in_valid && in_ready, latch a, b and borrow_in into the internal registers.
  - Clear the bit counter and go to SHIFT.
- SHIFT: each cycle take bit i = a_sr[0], b_sr[0], br.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - Shift d into the result register from the MSB end. Shift a_sr and b_sr right. Increment the counter.
  - After WIDTH bits, go to DONE. diff holds the full result and borrow_out = final br.
- DONE:
  - out_valid=1; diff and borrow_out are stable.
  - On out_valid && out_ready, go to IDLE and drop out_valid.
- Inputs a, b and borrow_in are ignored outside the IDLE acceptance edge. Changing them mid-operation has no effect.
- in_valid in SHIFT or DONE is not accepted. The producer must hold it until in_ready.
- diff and borrow_out are updated only by the SHIFT datapath. They keep their last value in IDLE until the next computation overwrites them.
- Arithmetic: unsigned modulo 2^WIDTH. Counter width is clog2(WIDTH+1).

## Timing
- Accept edge = E. SHIFT occupies edges E+1 .. E+WIDTH.
- out_valid rises after edge E+WIDTH: fixed latency of WIDTH cycles from acceptance to result.
- With out_ready held high, the result handshake completes at edge E+WIDTH+1. in_ready is high after that edge.
- Throughput: one operation per WIDTH+2 cycles maximum. No overlap between operations.
- Backpressure: out_ready low holds DONE indefinitely, with diff, borrow_out and out_valid constant.
- Simultaneous out handshake and in_valid: the new operand is not accepted on that same edge. It is accepted on the next edge in IDLE.
- Reset mid-operation (SHIFT or DONE):
  - All outputs go to their reset values immediately, asynchronously.
  - The partial result is discarded.
  - The block is ready for operands on the first edge after rst_n deasserts.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x05, b=0x03, borrow_in=0 → diff=0x02, borrow_out=0. out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1. Also a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - diff, borrow_out and out_valid stay constant; in_ready stays 0.
  - The new operands are accepted only after the result handshake.
- Assert rst_n=0 mid-SHIFT, after bit 3.
  - Outputs immediately read in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0.
  - After release, a=0xA0, b=0x0F, borrow_in=0 yields diff=0x91, borrow_out=0.
- Exhaustive, WIDTH=4: all 512 combinations of (a, b, borrow_in), back-to-back, with out_ready random.
  - Every result matches (a − b − borrow_in) mod 16, with borrow_out = (a < b + borrow_in).
  - Exactly one output handshake per input handshake.
- WIDTH=32 boundary: a=0x00000000, b=0xFFFFFFFF, borrow_in=1 → diff=0x00000000, borrow_out=1, latency 32 cycles.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, one bit per clock LSB-first,
// with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bout;
  logic             rdy;
  logic             vld;
  logic             bsy;
  logic             d;
  logic             br_nx;

  assign d     = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nx = (~a_sr[0] & b_sr[0])
               | (~(a_sr[0] ^ b_sr[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      bout  <= 1'b0;
      rdy   <= 1'b1;
      vld   <= 1'b0;
      bsy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.borrow_in;
            cnt   <= '0;
            state <= SHIFT;
            rdy   <= 1'b0;
            bsy   <= 1'b1;
          end
        end
        SHIFT: begin
          // Result fills from the MSB so bit 0 lands at the LSB last.
          res  <= {d, res[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            bout  <= br_nx;
            vld   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            vld   <= 1'b0;
            rdy   <= 1'b1;
            bsy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = vld;
  assign bus.busy       = bsy;
  assign bus.diff       = res;
  assign bus.borrow_out = bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 4, 8 and 32 against an
// arithmetic reference model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4))  i4 ();
  serial_subtractor_if #(.WIDTH(8))  i8 ();
  serial_subtractor_if #(.WIDTH(32)) i32 ();

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(i4.slave)
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(i8.slave)
  );
  serial_subtractor #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(i32.slave)
  );

  // {borrow, diff}: plain modular arithmetic on wide integers
  function automatic logic [32:0] model(
    input int w, input logic [31:0] a, input logic [31:0] b,
    input logic bin
  );
    longint unsigned mask, ra, rb, r;
    logic bo;
    mask = (64'd1 << w) - 64'd1;
    ra = 64'(a) & mask;
    rb = 64'(b) & mask;
    r  = (ra - rb - 64'(bin)) & mask;
    bo = ra < (rb + 64'(bin));
    return {bo, r[31:0]};
  endfunction

  task automatic set_in(
    input int w, input logic [31:0] a, input logic [31:0] b,
    input logic bin, input logic v
  );
    case (w)
      4: begin
        i4.a = a[3:0]; i4.b = b[3:0];
        i4.borrow_in = bin; i4.in_valid = v;
      end
      8: begin
        i8.a = a[7:0]; i8.b = b[7:0];
        i8.borrow_in = bin; i8.in_valid = v;
      end
      default: begin
        i32.a = a; i32.b = b;
        i32.borrow_in = bin; i32.in_valid = v;
      end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      4: i4.out_ready = r;
      8: i8.out_ready = r;
      default: i32.out_ready = r;
    endcase
  endtask

  function automatic logic [31:0] rd_diff(input int w);
    case (w)
      4: return 32'(i4.diff);
      8: return 32'(i8.diff);
      default: return i32.diff;
    endcase
  endfunction

  // {in_ready, out_valid, busy, borrow_out}
  function automatic logic [3:0] rd_st(input int w);
    case (w)
      4: return {i4.in_ready, i4.out_valid, i4.busy, i4.borrow_out};
      8: return {i8.in_ready, i8.out_valid, i8.busy, i8.borrow_out};
      default: return {i32.in_ready, i32.out_valid, i32.busy,
                       i32.borrow_out};
    endcase
  endfunction

  // One full transaction; lat counts cycles from accept edge to out_valid.
  task automatic op(
    input int w, input logic [31:0] a, input logic [31:0] b,
    input logic bin, output logic [31:0] d, output logic bo,
    output int lat
  );
    int g;
    logic [3:0] st;
    @(negedge clk);
    set_ordy(w, 1'b1);
    set_in(w, a, b, bin, 1'b1);
    g = 0;
    st = rd_st(w);
    while (!st[3] && g < 200) begin
      @(negedge clk); g++; st = rd_st(w);
    end
    @(negedge clk);
    set_in(w, a, b, bin, 1'b0);
    lat = 0;
    st = rd_st(w);
    while (!st[2] && lat < 200) begin
      @(negedge clk); lat++; st = rd_st(w);
    end
    d = rd_diff(w);
    bo = st[0];
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int w = 0; w < 3; w++) begin
      int wd;
      logic [3:0] st;
      wd = (w == 0) ? 4 : (w == 1) ? 8 : 32;
      st = rd_st(wd);
      vectors++;
      if (st !== 4'b1000 || rd_diff(wd) !== 32'd0) begin
        errors++;
        $display("FAIL reset_w%0d: st=%b diff=%h want st=1000 diff=0",
                 wd, st, rd_diff(wd));
      end
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic bo;
    int lat;
    logic [32:0] e;
    logic [3:0] st;
    op(8, 32'h05, 32'h03, 1'b0, d, bo, lat);
    vectors++;
    if ({bo, d} !== {1'b0, 32'h02} || lat != 8) begin
      errors++;
      $display("FAIL basic_5m3: got %b/%h lat %0d want 0/02 lat 8",
               bo, d, lat);
    end
    op(8, 32'h03, 32'h05, 1'b0, d, bo, lat);
    vectors++;
    if ({bo, d} !== {1'b1, 32'hFE}) begin
      errors++;
      $display("FAIL basic_3m5: got %b/%h want 1/fe", bo, d);
    end
    op(8, 32'h00, 32'h00, 1'b1, d, bo, lat);
    vectors++;
    if ({bo, d} !== {1'b1, 32'hFF}) begin
      errors++;
      $display("FAIL basic_0m0b: got %b/%h want 1/ff", bo, d);
    end
    repeat (3) @(negedge clk);
    st = rd_st(8);
    e = {1'b1, 32'hFF};
    vectors++;
    if ({st, rd_diff(8)} !== {3'b100, e[32], e[31:0]}) begin
      errors++;
      $display("FAIL idle_hold: st=%b diff=%h want st=100%b diff=%h",
               st, rd_diff(8), e[32], e[31:0]);
    end
  endtask

  task automatic test_random8;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b, d;
      logic bin, bo;
      int lat;
      logic [32:0] e;
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      e = model(8, a, b, bin);
      op(8, a, b, bin, d, bo, lat);
      vectors++;
      if ({bo, d} !== e || lat != 8) begin
        errors++;
        $display("FAIL rand8 %h-%h-%b: got %b/%h lat %0d want %b/%h lat 8",
                 a, b, bin, bo, d, lat, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, na, nb;
    logic bin, nbin;
    logic [32:0] e, ne;
    logic [3:0] st;
    int g;
    a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
    na = 32'($urandom_range(0, 255)); nb = 32'($urandom_range(0, 255));
    nbin = 1'($urandom_range(0, 1));
    e = model(8, a, b, bin);
    ne = model(8, na, nb, nbin);
    @(negedge clk);
    set_ordy(8, 1'b0);
    set_in(8, a, b, bin, 1'b1);
    g = 0; st = rd_st(8);
    while (!st[3] && g < 100) begin @(negedge clk); g++; st = rd_st(8); end
    @(negedge clk);
    set_in(8, na, nb, nbin, 1'b1);
    g = 0; st = rd_st(8);
    while (!st[2] && g < 100) begin @(negedge clk); g++; st = rd_st(8); end
    for (int k = 0; k < 5; k++) begin
      st = rd_st(8);
      vectors++;
      if ({st, rd_diff(8)} !== {3'b011, e[32], e[31:0]}) begin
        errors++;
        $display("FAIL bp_hold%0d: st=%b diff=%h want st=011%b diff=%h",
                 k, st, rd_diff(8), e[32], e[31:0]);
      end
      @(negedge clk);
    end
    set_ordy(8, 1'b1);
    @(negedge clk);
    st = rd_st(8);
    vectors++;
    if (st[3:1] !== 3'b100) begin
      errors++;
      $display("FAIL bp_release: st=%b want 100x", st);
    end
    @(negedge clk);
    st = rd_st(8);
    set_in(8, na, nb, nbin, 1'b0);
    vectors++;
    if (st[3:1] !== 3'b001) begin
      errors++;
      $display("FAIL bp_accept: st=%b want 001x", st);
    end
    g = 0; st = rd_st(8);
    while (!st[2] && g < 100) begin @(negedge clk); g++; st = rd_st(8); end
    vectors++;
    if ({st[0], rd_diff(8)} !== ne || g != 8) begin
      errors++;
      $display("FAIL bp_next: got %b/%h lat %0d want %b/%h lat 8",
               st[0], rd_diff(8), g, ne[32], ne[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic bo;
    int lat, g;
    logic [3:0] st;
    @(negedge clk);
    set_ordy(8, 1'b1);
    set_in(8, 32'h5A, 32'h33, 1'b1, 1'b1);
    g = 0; st = rd_st(8);
    while (!st[3] && g < 100) begin @(negedge clk); g++; st = rd_st(8); end
    @(negedge clk);
    set_in(8, 32'h5A, 32'h33, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    st = rd_st(8);
    vectors++;
    if (st !== 4'b1000 || rd_diff(8) !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: st=%b diff=%h want st=1000 diff=0",
               st, rd_diff(8));
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(8, 32'hA0, 32'h0F, 1'b0, d, bo, lat);
    vectors++;
    if ({bo, d} !== {1'b0, 32'h91} || lat != 8) begin
      errors++;
      $display("FAIL after_reset: got %b/%h lat %0d want 0/91 lat 8",
               bo, d, lat);
    end
  endtask

  task automatic test_exhaustive4;
    logic [32:0] q[$];
    int nin, nout, extra;
    logic [3:0] st;
    nin = 0; nout = 0; extra = 0;
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          int g;
          logic [8:0] v;
          logic [3:0] ps;
          v = 9'(i);
          @(negedge clk);
          set_in(4, 32'(v[8:5]), 32'(v[4:1]), v[0], 1'b1);
          g = 0; ps = rd_st(4);
          while (!ps[3] && g < 40) begin
            @(negedge clk); g++; ps = rd_st(4);
          end
          if (!ps[3]) begin
            errors++;
            $display("FAIL exh_accept_timeout: item %0d", i);
            break;
          end
          q.push_back(model(4, 32'(v[8:5]), 32'(v[4:1]), v[0]));
          nin++;
        end
        @(negedge clk);
        set_in(4, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      begin
        int g;
        logic r;
        logic [3:0] cs;
        logic [32:0] e;
        g = 0;
        while (nout < 512 && g < 20000) begin
          @(negedge clk); g++;
          r = 1'($urandom_range(0, 1));
          set_ordy(4, r);
          cs = rd_st(4);
          if (cs[2] && r) begin
            e = (q.size() > 0) ? q.pop_front() : 33'h1_FFFF_FFFF;
            vectors++;
            if ({cs[0], rd_diff(4)} !== e) begin
              errors++;
              $display("FAIL exh_result%0d: got %b/%h want %b/%h",
                       nout, cs[0], rd_diff(4), e[32], e[31:0]);
            end
            nout++;
          end
        end
      end
    join
    set_ordy(4, 1'b1);
    repeat (20) begin
      @(negedge clk);
      st = rd_st(4);
      if (st[2]) extra++;
    end
    vectors++;
    if (nin != 512 || nout != 512 || extra != 0) begin
      errors++;
      $display("FAIL exh_count: in %0d out %0d extra %0d want 512 512 0",
               nin, nout, extra);
    end
  endtask

  task automatic test_w32;
    logic [31:0] d;
    logic bo;
    int lat;
    op(32, 32'h0, 32'hFFFF_FFFF, 1'b1, d, bo, lat);
    vectors++;
    if ({bo, d} !== {1'b1, 32'h0} || lat != 32) begin
      errors++;
      $display("FAIL w32_edge: got %b/%h lat %0d want 1/00000000 lat 32",
               bo, d, lat);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic bin;
      logic [32:0] e;
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      e = model(32, a, b, bin);
      op(32, a, b, bin, d, bo, lat);
      vectors++;
      if ({bo, d} !== e || lat != 32) begin
        errors++;
        $display("FAIL w32_rand %h-%h-%b: got %b/%h lat %0d want %b/%h",
                 a, b, bin, bo, d, lat, e[32], e[31:0]);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 3; w++) begin
      int wd;
      wd = (w == 0) ? 4 : (w == 1) ? 8 : 32;
      set_in(wd, 32'd0, 32'd0, 1'b0, 1'b0);
      set_ordy(wd, 1'b0);
    end
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_random8;
    test_backpressure;
    test_reset_mid;
    test_exhaustive4;
    test_w32;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
